// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the RAM port reader and its skid FIFO.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam logic [127:0] PERF_LOW_LATENCY = "LOW_LATENCY";

  // Bits needed to hold the value 'depth' (address width when given depth-1).
  function automatic int clogb2(input int depth);
    int d;
    int r;
    d = depth;
    r = 0;
    while (d > 0) begin
      d = d >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  // The RAM's output register adds one cycle in HIGH_PERFORMANCE mode.
  function automatic int read_lat(input logic [127:0] perf);
    return (perf == PERF_LOW_LATENCY) ? 1 : 2;
  endfunction

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Fall-through skid FIFO catching RAM read data that is already in flight.
// A push into an empty FIFO is presented on the head in the same cycle.
module ram_rd_fifo_chk (
  input  logic clk,
  input  logic rst_n,
  input  logic store_i,
  input  logic full_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(store_i && full_i));

endmodule

module ram_rd_skid_fifo
  import ram_pkg::*;
#(
  parameter int  WIDTH = 18,
  parameter int  DEPTH = 4,
  localparam int PTR_W = clogb2(DEPTH - 1),
  localparam int CNT_W = clogb2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_s, full_s, store_s, take_s;

  assign empty_s = (count_q == CNT_ZERO);
  assign full_s  = (count_q == CNT_FULL);
  // A push that is popped straight through the bypass never occupies storage.
  assign store_s = push_i & ~(empty_s & pop_i);
  assign take_s  = pop_i & ~empty_s;
  assign valid_o = ~empty_s | push_i;
  assign count_o = count_q;

  // Head selection: stored entry, else bypassed push, else zero.
  always_comb begin
    if (!empty_s) begin
      data_o = mem_q[rd_ptr_q];
    end else if (push_i) begin
      data_o = data_i;
    end else begin
      data_o = {WIDTH{1'b0}};
    end
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (store_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (take_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({store_s, take_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (store_s && !full_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  ram_rd_fifo_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .store_i (store_s),
    .full_i  (full_s)
  );

endmodule

// File: rtl/ram_port_reader.sv
// Read-side initiator for a block RAM port: sweeps an address window and
// re-times the fixed-latency RAM output into a valid/ready stream.
module ram_port_reader
  import ram_pkg::*;
#(
  parameter int           RAM_WIDTH       = 18,
  parameter int           RAM_DEPTH       = 1024,
  parameter logic [127:0] RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter int           FIFO_DEPTH      = 4,
  localparam int          ADDR_W          = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [ADDR_W:0]      length,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic                 ram_regce,
  output logic                 ram_rst,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  localparam int LAT   = read_lat(RAM_PERFORMANCE);
  localparam int CNT_W = clogb2(FIFO_DEPTH);
  localparam int CR_W  = CNT_W + 1;

  localparam logic [CR_W-1:0]   CREDIT_LIM = CR_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   LEN_ZERO   = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W + 1)'(1);

  rd_state_t             state_q, state_d;
  logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]       issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]       beat_cnt_q, beat_cnt_d;
  logic [LAT-1:0]        lat_sr_q, lat_sr_d;
  logic [CNT_W-1:0]      fifo_count_s;
  logic [CR_W-1:0]       inflight_s, credit_used_s;
  logic                  issue_s, push_s, pop_s, last_s;
  logic                  fifo_valid_s;
  logic [RAM_WIDTH-1:0]  fifo_data_s;

  // Reads still inside the RAM pipeline hold a FIFO slot in reserve.
  always_comb begin
    inflight_s = {CR_W{1'b0}};
    for (int i = 0; i < LAT; i++) begin
      inflight_s = inflight_s + CR_W'(lat_sr_q[i]);
    end
  end

  assign credit_used_s = CR_W'(fifo_count_s) + inflight_s;
  assign issue_s       = (state_q == ISSUE) && (issue_cnt_q != LEN_ZERO) &&
                         (credit_used_s < CREDIT_LIM);
  assign lat_sr_d      = LAT'({lat_sr_q, issue_s});
  assign push_s        = lat_sr_q[LAT-1];
  assign pop_s         = fifo_valid_s & m_ready;
  assign last_s        = fifo_valid_s && (beat_cnt_q == LEN_ONE);

  // Sweep sequencing and address/count bookkeeping.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    issue_cnt_d = issue_cnt_q;
    if (pop_s && (beat_cnt_q != LEN_ZERO)) begin
      beat_cnt_d = beat_cnt_q - LEN_ONE;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
    case (state_q)
      IDLE: begin
        if (start && (length != LEN_ZERO)) begin
          state_d     = ISSUE;
          cur_addr_d  = start_addr;
          issue_cnt_d = length;
          beat_cnt_d  = length;
        end else if (start) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (issue_s) begin
          cur_addr_d  = (cur_addr_q == LAST_ADDR) ? ADDR_ZERO : cur_addr_q + ADDR_W'(1);
          issue_cnt_d = issue_cnt_q - LEN_ONE;
          state_d     = (issue_cnt_q == LEN_ONE) ? DRAIN : ISSUE;
        end else if (issue_cnt_q == LEN_ZERO) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (pop_s && last_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller state, counters and latency tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= ADDR_ZERO;
      issue_cnt_q <= LEN_ZERO;
      beat_cnt_q  <= LEN_ZERO;
      lat_sr_q    <= {LAT{1'b0}};
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      lat_sr_q    <= lat_sr_d;
    end
  end

  ram_rd_skid_fifo #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .data_i  (ram_dout),
    .pop_i   (pop_s),
    .valid_o (fifo_valid_s),
    .data_o  (fifo_data_s),
    .count_o (fifo_count_s)
  );

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign ram_en    = issue_s;
  assign ram_addr  = cur_addr_q;
  assign ram_we    = 1'b0;
  assign ram_regce = 1'b1;
  assign ram_rst   = 1'b0;
  assign m_valid   = fifo_valid_s;
  assign m_data    = fifo_data_s;
  assign m_last    = last_s;

endmodule

// File: tb/tb_ram_port_reader.sv
// Directed bench for ram_port_reader with behavioural RAMs holding data[i] = i.
module tb_ram_port_reader;

  localparam int W  = 18;
  localparam int D  = 1024;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start_hp, start_ll, m_ready;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;

  logic          busy_hp, done_hp, ram_en_hp, ram_we_hp, ram_regce_hp, ram_rst_hp;
  logic          m_valid_hp, m_last_hp;
  logic [AW-1:0] ram_addr_hp;
  logic [W-1:0]  m_data_hp;
  logic [W-1:0]  ram_q_hp    = '0;
  logic [W-1:0]  ram_dout_hp = '0;

  logic          busy_ll, done_ll, ram_en_ll, ram_we_ll, ram_regce_ll, ram_rst_ll;
  logic          m_valid_ll, m_last_ll;
  logic [AW-1:0] ram_addr_ll;
  logic [W-1:0]  m_data_ll;
  logic [W-1:0]  ram_dout_ll = '0;

  int passed = 0;
  int total  = 0;

  ram_port_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_PERFORMANCE("HIGH_PERFORMANCE"),
                    .FIFO_DEPTH(4)) dut_hp (
    .clk(clk), .rst_n(rst_n), .start(start_hp), .start_addr(start_addr), .length(length),
    .busy(busy_hp), .done(done_hp), .ram_addr(ram_addr_hp), .ram_en(ram_en_hp),
    .ram_we(ram_we_hp), .ram_regce(ram_regce_hp), .ram_rst(ram_rst_hp),
    .ram_dout(ram_dout_hp), .m_data(m_data_hp), .m_valid(m_valid_hp),
    .m_ready(m_ready), .m_last(m_last_hp));

  ram_port_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_PERFORMANCE("LOW_LATENCY"),
                    .FIFO_DEPTH(4)) dut_ll (
    .clk(clk), .rst_n(rst_n), .start(start_ll), .start_addr(start_addr), .length(length),
    .busy(busy_ll), .done(done_ll), .ram_addr(ram_addr_ll), .ram_en(ram_en_ll),
    .ram_we(ram_we_ll), .ram_regce(ram_regce_ll), .ram_rst(ram_rst_ll),
    .ram_dout(ram_dout_ll), .m_data(m_data_ll), .m_valid(m_valid_ll),
    .m_ready(m_ready), .m_last(m_last_ll));

  // RAM contents are data[i] = i, so the read value is the address itself.
  always @(posedge clk) begin
    if (ram_en_hp) ram_q_hp <= W'(ram_addr_hp);
    ram_dout_hp <= ram_q_hp;
    if (ram_en_ll) ram_dout_ll <= W'(ram_addr_ll);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one nanosecond into the first cycle after start was sampled.
  task automatic pulse_start(input bit ll, input logic [AW-1:0] a, input logic [AW:0] n);
    tick();
    start_addr = a;
    length     = n;
    if (ll) start_ll = 1'b1;
    else    start_hp = 1'b1;
    tick();
    start_hp = 1'b0;
    start_ll = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_hp = 1'b0; start_ll = 1'b0; m_ready = 1'b1;
    start_addr = '0; length = '0;
    repeat (3) tick();
    #1;
    total++;
    if ({busy_hp, done_hp, ram_en_hp, m_valid_hp, m_last_hp, ram_addr_hp} !== 15'd0) begin
      $display("FAIL reset_hp got %b want 0",
               {busy_hp, done_hp, ram_en_hp, m_valid_hp, m_last_hp, ram_addr_hp});
    end else passed++;
    total++;
    if ({busy_ll, done_ll, ram_en_ll, m_valid_ll, m_last_ll, ram_addr_ll} !== 15'd0) begin
      $display("FAIL reset_ll got %b want 0",
               {busy_ll, done_ll, ram_en_ll, m_valid_ll, m_last_ll, ram_addr_ll});
    end else passed++;
    total++;
    if ({ram_we_hp, ram_regce_hp, ram_rst_hp} !== 3'b010) begin
      $display("FAIL ram_ctrl_const got %b want 010", {ram_we_hp, ram_regce_hp, ram_rst_hp});
    end else passed++;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    pulse_start(1'b0, 10'd10, 11'd5);
    for (int c = 1; c <= 9; c++) begin
      #1;
      total++;
      if (ram_en_hp !== (c <= 5)) begin
        $display("FAIL basic_en c=%0d got %b want %b", c, ram_en_hp, (c <= 5));
      end else passed++;
      if (c <= 5) begin
        total++;
        if (ram_addr_hp !== AW'(9 + c)) begin
          $display("FAIL basic_addr c=%0d got %0d want %0d", c, ram_addr_hp, 9 + c);
        end else passed++;
      end
      total++;
      if (m_valid_hp !== (c >= 3 && c <= 7)) begin
        $display("FAIL basic_valid c=%0d got %b want %b", c, m_valid_hp, (c >= 3 && c <= 7));
      end else passed++;
      if (c >= 3 && c <= 7) begin
        total++;
        if (m_data_hp !== W'(7 + c)) begin
          $display("FAIL basic_data c=%0d got %0d want %0d", c, m_data_hp, 7 + c);
        end else passed++;
      end
      total++;
      if (m_last_hp !== (c == 7)) begin
        $display("FAIL basic_last c=%0d got %b want %b", c, m_last_hp, (c == 7));
      end else passed++;
      total++;
      if (done_hp !== (c == 8)) begin
        $display("FAIL basic_done c=%0d got %b want %b", c, done_hp, (c == 8));
      end else passed++;
      total++;
      if (busy_hp !== (c <= 7)) begin
        $display("FAIL basic_busy c=%0d got %b want %b", c, busy_hp, (c <= 7));
      end else passed++;
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    exp_a = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    pulse_start(1'b0, 10'd1022, 11'd4);
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (c <= 4) begin
        total++;
        if (ram_en_hp !== 1'b1 || ram_addr_hp !== exp_a[c-1]) begin
          $display("FAIL wrap_addr c=%0d got en=%b addr=%0d want en=1 addr=%0d",
                   c, ram_en_hp, ram_addr_hp, exp_a[c-1]);
        end else passed++;
      end
      if (c >= 3 && c <= 6) begin
        total++;
        if (m_valid_hp !== 1'b1 || m_data_hp !== W'(exp_a[c-3])) begin
          $display("FAIL wrap_data c=%0d got v=%b d=%0d want v=1 d=%0d",
                   c, m_valid_hp, m_data_hp, exp_a[c-3]);
        end else passed++;
      end
      if (c == 7) begin
        total++;
        if (done_hp !== 1'b1) $display("FAIL wrap_done got %b want 1", done_hp);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit           pat [4];
    int           idx, issued, popped;
    bit           held_v, seen_done;
    logic [W-1:0] held;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    idx = 0; issued = 0; popped = 0; held_v = 1'b0; seen_done = 1'b0; held = '0;
    pulse_start(1'b0, 10'd0, 11'd8);
    for (int c = 1; c <= 60 && !seen_done; c++) begin
      m_ready = pat[(c - 1) % 4];
      #1;
      if (ram_en_hp) issued++;
      total++;
      if (issued - popped > 4) begin
        $display("FAIL bp_credit c=%0d got %0d outstanding want <=4", c, issued - popped);
      end else passed++;
      if (held_v) begin
        total++;
        if (m_valid_hp !== 1'b1 || m_data_hp !== held) begin
          $display("FAIL bp_stable c=%0d got v=%b d=%0d want v=1 d=%0d",
                   c, m_valid_hp, m_data_hp, held);
        end else passed++;
      end
      if (m_valid_hp && m_ready) begin
        total++;
        if (m_data_hp !== W'(idx) || m_last_hp !== (idx == 7)) begin
          $display("FAIL bp_beat idx=%0d got d=%0d last=%b want d=%0d last=%b",
                   idx, m_data_hp, m_last_hp, idx, (idx == 7));
        end else passed++;
        idx++;
        popped++;
        held_v = 1'b0;
      end else if (m_valid_hp) begin
        held_v = 1'b1;
        held   = m_data_hp;
      end
      if (done_hp) seen_done = 1'b1;
      tick();
    end
    m_ready = 1'b1;
    total++;
    if (idx != 8 || !seen_done) begin
      $display("FAIL bp_total got beats=%0d done=%b want beats=8 done=1", idx, seen_done);
    end else passed++;
  endtask

  task automatic test_zero_length();
    pulse_start(1'b0, 10'd5, 11'd0);
    #1;
    total++;
    if ({done_hp, ram_en_hp, m_valid_hp, busy_hp} !== 4'b1000) begin
      $display("FAIL zero_len_c1 got %b want 1000", {done_hp, ram_en_hp, m_valid_hp, busy_hp});
    end else passed++;
    tick();
    #1;
    total++;
    if ({done_hp, ram_en_hp, m_valid_hp} !== 3'b000) begin
      $display("FAIL zero_len_c2 got %b want 000", {done_hp, ram_en_hp, m_valid_hp});
    end else passed++;
    tick();
  endtask

  task automatic test_start_ignored();
    int beats, issues, dones;
    beats = 0; issues = 0; dones = 0;
    pulse_start(1'b0, 10'd100, 11'd3);
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin
        start_hp = 1'b1; start_addr = 10'd200; length = 11'd5;
      end else begin
        start_hp = 1'b0;
      end
      #1;
      if (ram_en_hp) issues++;
      if (done_hp) dones++;
      if (m_valid_hp && m_ready) begin
        total++;
        if (m_data_hp !== W'(100 + beats)) begin
          $display("FAIL ignore_data beat=%0d got %0d want %0d", beats, m_data_hp, 100 + beats);
        end else passed++;
        beats++;
      end
      tick();
    end
    total++;
    if (beats != 3 || issues != 3 || dones != 1) begin
      $display("FAIL ignore_counts got beats=%0d issues=%0d dones=%0d want 3 3 1",
               beats, issues, dones);
    end else passed++;
  endtask

  task automatic test_low_latency_full();
    int errs, first_bad, issues;
    errs = 0; first_bad = -1; issues = 0;
    pulse_start(1'b1, 10'd0, 11'd1024);
    for (int c = 1; c <= 1027; c++) begin
      #1;
      if (ram_en_ll) issues++;
      if (c == 1) begin
        total++;
        if (ram_en_ll !== 1'b1 || m_valid_ll !== 1'b0) begin
          $display("FAIL ll_first_cycle got en=%b v=%b want en=1 v=0", ram_en_ll, m_valid_ll);
        end else passed++;
      end
      if (c == 2) begin
        total++;
        if (m_valid_ll !== 1'b1 || m_data_ll !== 18'd0) begin
          $display("FAIL ll_first_valid got v=%b d=%0d want v=1 d=0", m_valid_ll, m_data_ll);
        end else passed++;
      end
      if (c >= 2 && c <= 1025) begin
        if (m_valid_ll !== 1'b1 || m_data_ll !== W'(c - 2) || m_last_ll !== (c == 1025)) begin
          errs++;
          if (first_bad < 0) first_bad = c;
        end
      end
      if (c == 1026) begin
        total++;
        if (done_ll !== 1'b1 || m_valid_ll !== 1'b0) begin
          $display("FAIL ll_done got done=%b v=%b want done=1 v=0", done_ll, m_valid_ll);
        end else passed++;
      end
      tick();
    end
    total++;
    if (errs != 0) begin
      $display("FAIL ll_stream got %0d bad cycles (first c=%0d) want 0", errs, first_bad);
    end else passed++;
    total++;
    if (issues != 1024) begin
      $display("FAIL ll_issues got %0d want 1024", issues);
    end else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    int beats, bad;
    bit seen_done;
    beats = 0; bad = 0; seen_done = 1'b0;
    pulse_start(1'b0, 10'd50, 11'd10);
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (m_valid_hp && m_ready) beats++;
      tick();
    end
    total++;
    if (beats != 3) $display("FAIL mid_pre_beats got %0d want 3", beats);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy_hp, done_hp, ram_en_hp, m_valid_hp, m_last_hp, ram_addr_hp, m_data_hp} !== 33'd0) begin
      $display("FAIL mid_reset_outs got %b want 0",
               {busy_hp, done_hp, ram_en_hp, m_valid_hp, m_last_hp, ram_addr_hp, m_data_hp});
    end else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (m_valid_hp || done_hp || ram_en_hp) bad++;
      tick();
    end
    total++;
    if (bad != 0) $display("FAIL mid_quiet got %0d active cycles want 0", bad);
    else passed++;
    beats = 0;
    pulse_start(1'b0, 10'd300, 11'd3);
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (m_valid_hp && m_ready) begin
        total++;
        if (m_data_hp !== W'(300 + beats)) begin
          $display("FAIL mid_resweep_data beat=%0d got %0d want %0d", beats, m_data_hp, 300 + beats);
        end else passed++;
        beats++;
      end
      if (done_hp) seen_done = 1'b1;
      tick();
    end
    total++;
    if (beats != 3 || !seen_done) begin
      $display("FAIL mid_resweep got beats=%0d done=%b want 3 1", beats, seen_done);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_start_ignored();
    test_low_latency_full();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
